// File: rtl/pair_input_conditioner.sv
// Two-line synchroniser plus pair debouncer feeding the i1/i2 recogniser.
// The pair is accepted as a unit, so no transient combination reaches i1/i2.
module pair_input_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i1_raw,
  input  logic i2_raw,
  input  logic hold,
  output logic i1,
  output logic i2,
  output logic chg
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sy1_q;
  logic [SYNC_STAGES-1:0] sy2_q;
  logic [1:0]             s;

  logic [1:0]    cand_q;
  logic [1:0]    cand_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [1:0]    out_q;
  logic [1:0]    out_d;
  logic          chg_q;
  logic          chg_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sy1_q <= '0;
      sy2_q <= '0;
    end else begin
      sy1_q <= {sy1_q[SYNC_STAGES-2:0], i1_raw};
      sy2_q <= {sy2_q[SYNC_STAGES-2:0], i2_raw};
    end
  end

  assign s = {sy1_q[SYNC_STAGES-1], sy2_q[SYNC_STAGES-1]};

  // Any synchronised change restarts qualification from zero.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = '0;
    out_d  = out_q;
    chg_d  = 1'b0;
    if (s != cand_q) begin
      cand_d = s;
    end else if (hold) begin
      cnt_d = '0;
    end else if (cand_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d = cand_q;
      chg_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      chg_q  <= chg_d;
    end
  end

  assign i1  = out_q[1];
  assign i2  = out_q[0];
  assign chg = chg_q;

endmodule
